// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard and forwarding controller for the five-stage IF/ID/EX/MEM/WB core.
//   It shadows the destination tags of the instructions in EX, MEM and WB.
//   From those tags it derives the stall/bubble controls, the EX-stage
//   forwarding selects and a multi-cycle IF/ID flush after a redirect.
//
//   Build option: PIPE_HAZARD_FWD_EN
//     defined   - EX operands are forwarded from MEM/WB; only load-use stalls.
//     undefined - fwd_sel is tied to 0; any in-flight producer stalls ID
//                 until it has left WB.
//
// Ports
//   clk, reset_n   core clock, synchronous active-low reset
//   id_valid       ID instruction valid
//   id_rs          ID source indices, src i at [i*REG_AW +: REG_AW]
//   id_rs_used     per-source "actually read" flags
//   id_rd          ID destination index
//   id_regwrite    ID instruction writes id_rd
//   id_memread     ID instruction is a load
//   redirect       taken branch/jump resolved in ID
//   stall_if       hold PC and IF/ID
//   stall_id       hold ID outputs
//   bubble_ex      load a NOP into ID/EX
//   flush_id       invalidate IF/ID
//   fwd_sel        per-source EX operand select (0 ID/EX, 1 EX/MEM, 2 MEM/WB)
//   stall_cnt      saturating count of stall cycles
//   flush_cnt      saturating count of flush cycles
module pipe_hazard_ctrl #(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned NSRC        = 2,
  parameter int unsigned FLUSH_DEPTH = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     id_valid,
  input  logic [NSRC*REG_AW-1:0]   id_rs,
  input  logic [NSRC-1:0]          id_rs_used,
  input  logic [REG_AW-1:0]        id_rd,
  input  logic                     id_regwrite,
  input  logic                     id_memread,
  input  logic                     redirect,
  output logic                     stall_if,
  output logic                     stall_id,
  output logic                     bubble_ex,
  output logic                     flush_id,
  output logic [NSRC*2-1:0]        fwd_sel,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         flush_cnt
);

  localparam int unsigned FC_W = 3;
  localparam logic [FC_W-1:0] FLUSH_RELOAD = FC_W'(FLUSH_DEPTH - 1);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } tag_t;

  tag_t                 ex_q;
  tag_t                 mem_q;
  tag_t                 wb_q;
  tag_t                 id_tag;
  logic [FC_W-1:0]      fcnt_q;

  logic                 hit_ex;
  logic                 hit_mem;
  logic                 hit_wb;
  logic                 hazard;
  logic                 stall;
  logic                 flush_active;
  logic                 issue;

  // A source depends on a slot when it is really read, is not x0, and the
  // slot holds a valid register writer of that index.
  function automatic logic src_hit(input tag_t s, input logic [REG_AW-1:0] rs,
                                   input logic used);
    return used && (rs != '0) && s.valid && s.regwrite && (s.rd == rs);
  endfunction

  assign id_tag = '{valid: 1'b1, rd: id_rd, regwrite: id_regwrite,
                    memread: id_memread};

  // ID-source dependency scan against every in-flight slot.
  always_comb begin
    hit_ex  = 1'b0;
    hit_mem = 1'b0;
    hit_wb  = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      hit_ex  = hit_ex  | src_hit(ex_q,  id_rs[i*REG_AW +: REG_AW], id_rs_used[i]);
      hit_mem = hit_mem | src_hit(mem_q, id_rs[i*REG_AW +: REG_AW], id_rs_used[i]);
      hit_wb  = hit_wb  | src_hit(wb_q,  id_rs[i*REG_AW +: REG_AW], id_rs_used[i]);
    end
  end

`ifdef PIPE_HAZARD_FWD_EN
  // With forwarding only a load still in EX cannot supply its result.
  assign hazard = id_valid & hit_ex & ex_q.memread;
`else
  // Without bypassing the register file, wait until the producer retires.
  assign hazard = id_valid & (hit_ex | hit_mem | hit_wb);
`endif

  // A redirect discards the ID instruction, so it must never be held.
  assign flush_active = (fcnt_q != '0);
  assign flush_id     = redirect | flush_active;
  assign stall        = hazard & ~redirect;
  assign stall_if     = stall;
  assign stall_id     = stall;
  assign bubble_ex    = stall | redirect;
  assign issue        = id_valid & ~stall & ~flush_id;

`ifdef PIPE_HAZARD_FWD_EN
  logic [NSRC*REG_AW-1:0] ex_rs_q;
  logic [NSRC-1:0]        ex_rs_used_q;

  // EX sources are kept only to resolve forwarding.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ex_rs_q      <= '0;
      ex_rs_used_q <= '0;
    end else if (issue) begin
      ex_rs_q      <= id_rs;
      ex_rs_used_q <= id_rs_used;
    end else begin
      ex_rs_q      <= '0;
      ex_rs_used_q <= '0;
    end
  end

  // Youngest producer (MEM) wins over the older one (WB).
  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (ex_q.valid && src_hit(mem_q, ex_rs_q[i*REG_AW +: REG_AW], ex_rs_used_q[i]))
        fwd_sel[2*i +: 2] = 2'd1;
      else if (ex_q.valid && src_hit(wb_q, ex_rs_q[i*REG_AW +: REG_AW], ex_rs_used_q[i]))
        fwd_sel[2*i +: 2] = 2'd2;
    end
  end
`else
  assign fwd_sel = '0;
`endif

  // Tag pipeline, flush down-counter and performance counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      fcnt_q    <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= issue ? id_tag : tag_t'('0);

      // The redirect cycle itself is flushed combinationally; the counter
      // covers the remaining FLUSH_DEPTH-1 cycles.
      if (redirect)
        fcnt_q <= FLUSH_RELOAD;
      else if (flush_active)
        fcnt_q <= fcnt_q - FC_W'(1);

      if (stall_id && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_id && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (REG_AW=5, NSRC=2, FLUSH_DEPTH=2).
// The driver applies one directed vector per cycle and queues the
// hand-computed expected outputs; the monitor checks them mid-cycle.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        id_valid;
  logic [9:0]  id_rs;
  logic [1:0]  id_rs_used;
  logic [4:0]  id_rd;
  logic        id_regwrite;
  logic        id_memread;
  logic        redirect;
  logic        stall_if;
  logic        stall_id;
  logic        bubble_ex;
  logic        flush_id;
  logic [3:0]  fwd_sel;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  int checks = 0;
  int errors = 0;
  int vec_no = 0;

  typedef struct {
    int         id;
    logic       st;
    logic       bu;
    logic       fl;
    logic [3:0] fw;
    int         sc;
    int         fc;
  } exp_t;

  exp_t sb[$];

  pipe_hazard_ctrl #(.REG_AW(5), .NSRC(2), .FLUSH_DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs(id_rs),
    .id_rs_used(id_rs_used), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .redirect(redirect), .stall_if(stall_if),
    .stall_id(stall_id), .bubble_ex(bubble_ex), .flush_id(flush_id),
    .fwd_sel(fwd_sel), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int id, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0d expected %0d", name, id, act, exp);
    end
  endtask

  // Monitor: outputs are presented every cycle, checked at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("stall_if",  e.id, int'(stall_if),  int'(e.st));
        chk("stall_id",  e.id, int'(stall_id),  int'(e.st));
        chk("bubble_ex", e.id, int'(bubble_ex), int'(e.bu));
        chk("flush_id",  e.id, int'(flush_id),  int'(e.fl));
        chk("fwd_sel",   e.id, int'(fwd_sel),   int'(e.fw));
        chk("stall_cnt", e.id, int'(stall_cnt), e.sc);
        chk("flush_cnt", e.id, int'(flush_cnt), e.fc);
      end
    end
  end

  // One cycle of stimulus plus its expected response.
  task automatic vec(input logic rstn, input logic v,
                     input logic [4:0] rs0, input logic u0,
                     input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rd, input logic rw, input logic mr,
                     input logic rdr,
                     input logic e_st, input logic e_bu, input logic e_fl,
                     input logic [3:0] e_fw, input int e_sc, input int e_fc);
    exp_t e;
    reset_n     = rstn;
    id_valid    = v;
    id_rs       = {rs1, rs0};
    id_rs_used  = {u1, u0};
    id_rd       = rd;
    id_regwrite = rw;
    id_memread  = mr;
    redirect    = rdr;
    e.id = vec_no; e.st = e_st; e.bu = e_bu; e.fl = e_fl;
    e.fw = e_fw;   e.sc = e_sc; e.fc = e_fc;
    sb.push_back(e);
    vec_no++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int budget;
    reset_n = 1'b0; id_valid = 1'b0; id_rs = '0; id_rs_used = '0;
    id_rd = '0; id_regwrite = 1'b0; id_memread = 1'b0; redirect = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    //   rstn v  rs0  u0 rs1  u1 rd  rw mr rdr  st bu fl fw       sc fc
`ifdef PIPE_HAZARD_FWD_EN
    vec(1, 0, 0,  0, 0,  0, 0,  0, 0, 0,   0, 0, 0, 4'b0000, 0, 0); // reset state
    vec(1, 1, 1,  1, 0,  0, 5,  1, 1, 0,   0, 0, 0, 4'b0000, 0, 0); // lw x5,0(x1)
    vec(1, 1, 5,  1, 7,  1, 6,  1, 0, 0,   1, 1, 0, 4'b0000, 0, 0); // add x6,x5,x7 load-use
    vec(1, 1, 5,  1, 7,  1, 6,  1, 0, 0,   0, 0, 0, 4'b0000, 1, 0); // add issues
    vec(1, 1, 1,  1, 2,  1, 3,  1, 0, 0,   0, 0, 0, 4'b0010, 1, 0); // add x3; add in EX src0=WB
    vec(1, 1, 3,  1, 3,  1, 4,  1, 0, 0,   0, 0, 0, 4'b0000, 1, 0); // sub x4,x3,x3
    vec(1, 1, 0,  1, 0,  0, 8,  1, 0, 0,   0, 0, 0, 4'b0101, 1, 0); // addi x8; sub fwd {1,1}
    vec(1, 1, 0,  1, 0,  0, 8,  1, 0, 0,   0, 0, 0, 4'b0000, 1, 0); // addi x8
    vec(1, 1, 8,  1, 0,  1, 9,  1, 0, 0,   0, 0, 0, 4'b0000, 1, 0); // or x9,x8,x0
    vec(1, 0, 0,  0, 0,  0, 0,  0, 0, 0,   0, 0, 0, 4'b0001, 1, 0); // or in EX: MEM wins
    vec(1, 1, 0,  1, 0,  0, 0,  1, 0, 0,   0, 0, 0, 4'b0000, 1, 0); // addi x0,x0,1
    vec(1, 1, 0,  1, 0,  1, 1,  1, 0, 0,   0, 0, 0, 4'b0000, 1, 0); // add x1,x0,x0
    vec(1, 0, 0,  0, 0,  0, 0,  0, 0, 0,   0, 0, 0, 4'b0000, 1, 0); // x0 never forwarded
    vec(1, 1, 0,  0, 0,  0, 5,  1, 1, 0,   0, 0, 0, 4'b0000, 1, 0); // lw x5
    vec(1, 1, 5,  1, 7,  1, 6,  1, 0, 1,   0, 1, 1, 4'b0000, 1, 0); // load-use + redirect
    vec(1, 0, 0,  0, 0,  0, 0,  0, 0, 0,   0, 0, 1, 4'b0000, 1, 1); // flush tail
    vec(1, 0, 0,  0, 0,  0, 0,  0, 0, 0,   0, 0, 0, 4'b0000, 1, 2); // flush done
    vec(1, 0, 0,  0, 0,  0, 0,  0, 0, 1,   0, 1, 1, 4'b0000, 1, 2); // redirect
    vec(0, 0, 0,  0, 0,  0, 0,  0, 0, 0,   0, 0, 1, 4'b0000, 1, 3); // reset mid-flush
    vec(1, 0, 0,  0, 0,  0, 0,  0, 0, 0,   0, 0, 0, 4'b0000, 0, 0); // flush aborted
`else
    vec(1, 0, 0,  0, 0,  0, 0,  0, 0, 0,   0, 0, 0, 4'b0000, 0, 0); // reset state
    vec(1, 1, 1,  1, 2,  1, 3,  1, 0, 0,   0, 0, 0, 4'b0000, 0, 0); // add x3,x1,x2
    vec(1, 1, 3,  1, 1,  1, 4,  1, 0, 0,   1, 1, 0, 4'b0000, 0, 0); // sub x4,x3,x1: x3 in EX
    vec(1, 1, 3,  1, 1,  1, 4,  1, 0, 0,   1, 1, 0, 4'b0000, 1, 0); // x3 in MEM
    vec(1, 1, 3,  1, 1,  1, 4,  1, 0, 0,   1, 1, 0, 4'b0000, 2, 0); // x3 in WB
    vec(1, 1, 3,  1, 1,  1, 4,  1, 0, 0,   0, 0, 0, 4'b0000, 3, 0); // sub issues
    vec(1, 1, 0,  1, 0,  0, 0,  1, 0, 0,   0, 0, 0, 4'b0000, 3, 0); // addi x0,x0,1
    vec(1, 1, 0,  1, 0,  1, 1,  1, 0, 0,   0, 0, 0, 4'b0000, 3, 0); // add x1,x0,x0
    vec(1, 1, 4,  0, 5,  1, 6,  1, 0, 0,   0, 0, 0, 4'b0000, 3, 0); // x4 unused: no stall
    vec(1, 0, 6,  1, 0,  0, 0,  0, 0, 0,   0, 0, 0, 4'b0000, 3, 0); // id_valid=0: no hazard
    vec(1, 1, 2,  1, 0,  0, 5,  1, 1, 0,   0, 0, 0, 4'b0000, 3, 0); // lw x5,0(x2)
    vec(1, 1, 5,  1, 7,  1, 6,  1, 0, 1,   0, 1, 1, 4'b0000, 3, 0); // load-use + redirect
    vec(1, 0, 0,  0, 0,  0, 0,  0, 0, 0,   0, 0, 1, 4'b0000, 3, 1); // flush tail
    vec(1, 0, 0,  0, 0,  0, 0,  0, 0, 0,   0, 0, 0, 4'b0000, 3, 2); // flush done
    vec(1, 0, 0,  0, 0,  0, 0,  0, 0, 1,   0, 1, 1, 4'b0000, 3, 2); // redirect at t
    vec(1, 0, 0,  0, 0,  0, 0,  0, 0, 1,   0, 1, 1, 4'b0000, 3, 3); // redirect at t+1
    vec(1, 0, 0,  0, 0,  0, 0,  0, 0, 0,   0, 0, 1, 4'b0000, 3, 4); // extended to t+2
    vec(1, 0, 0,  0, 0,  0, 0,  0, 0, 0,   0, 0, 0, 4'b0000, 3, 5); // flush done
    vec(1, 1, 0,  0, 0,  0, 5,  1, 1, 0,   0, 0, 0, 4'b0000, 3, 5); // lw x5
    vec(1, 1, 5,  1, 7,  1, 6,  1, 0, 0,   1, 1, 0, 4'b0000, 3, 5); // add x6,x5,x7
    vec(1, 1, 5,  1, 7,  1, 6,  1, 0, 0,   1, 1, 0, 4'b0000, 4, 5);
    vec(1, 1, 5,  1, 7,  1, 6,  1, 0, 0,   1, 1, 0, 4'b0000, 5, 5);
    vec(1, 1, 5,  1, 7,  1, 6,  1, 0, 0,   0, 0, 0, 4'b0000, 6, 5); // add issues
    vec(1, 1, 0,  0, 0,  0, 9,  1, 0, 0,   0, 0, 0, 4'b0000, 6, 5); // writer x9
    vec(1, 1, 9,  1, 0,  0, 10, 1, 0, 0,   1, 1, 0, 4'b0000, 6, 5); // reader x9 stalls
    vec(0, 1, 9,  1, 0,  0, 10, 1, 0, 0,   1, 1, 0, 4'b0000, 7, 5); // reset mid-stall
    vec(1, 1, 9,  1, 0,  0, 10, 1, 0, 0,   0, 0, 0, 4'b0000, 0, 0); // stall aborted
    vec(1, 0, 0,  0, 0,  0, 0,  0, 0, 1,   0, 1, 1, 4'b0000, 0, 0); // redirect
    vec(0, 0, 0,  0, 0,  0, 0,  0, 0, 0,   0, 0, 1, 4'b0000, 0, 1); // reset mid-flush
    vec(1, 0, 0,  0, 0,  0, 0,  0, 0, 0,   0, 0, 0, 4'b0000, 0, 0); // flush aborted
`endif
    budget = 10;
    while (sb.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    checks++;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard and forwarding controller for the five-stage IF/ID/EX/MEM/WB core. It shadows the destination tags of in-flight instructions in EX, MEM and WB. It produces:
- stall and bubble controls for load-use and unresolved dependencies;
- per-source forwarding selects for the instruction in EX;
- a multi-cycle IF/ID flush on control-flow redirect.

It sits beside the stage modules in the core top and replaces the current stall-free, forward-free pipeline assumption.

## Interface
Parameters:
- REG_AW, 5, register index width (x0 = all zeros, never a hazard).
- NSRC, 2, number of source operands per instruction.
- FLUSH_DEPTH, 2, cycles `flush_id` is held after a redirect (1..7).
- CNT_W, 16, width of the saturating stall/flush performance counters.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- id_valid  in  1  instruction in ID is valid.
- id_rs  in  NSRC*REG_AW  source register indices of the ID instruction; src i at [i*REG_AW +: REG_AW].
- id_rs_used  in  NSRC  source i is actually read.
- id_rd  in  REG_AW  destination of the ID instruction.
- id_regwrite  in  1  ID instruction writes `id_rd`.
- id_memread  in  1  ID instruction is a load.
- redirect  in  1  taken branch/jump resolved in ID (control_j).
- stall_if  out  1  hold PC and IF/ID register.
- stall_id  out  1  hold ID outputs.
- bubble_ex  out  1  load a NOP into ID/EX.
- flush_id  out  1  invalidate the IF/ID register.
- fwd_sel  out  NSRC*2  per-source operand select for the EX instruction:
  - 0 = ID/EX value;
  - 1 = EX/MEM alu_result;
  - 2 = MEM/WB write_data.
- stall_cnt  out  CNT_W  saturating count of stall cycles.
- flush_cnt  out  CNT_W  saturating count of `flush_id` cycles.

## Operation
- Tag pipeline:
  - Three registered tag slots, EX, MEM and WB, each holding {valid, rd, regwrite, memread}.
  - The EX slot also holds the rs indices and rs_used of the EX instruction.
  - Every cycle: WB←MEM, MEM←EX.
  - EX←ID tag when `issue`; otherwise EX←invalid (bubble).
  - `issue` = id_valid & !stall_id & !flush_id.
- Match rule: source i of the ID instruction matches slot S when all of the following hold:
  - id_rs_used[i];
  - rs_i != 0;
  - S.valid & S.regwrite & S.rd == rs_i.
- Load-use hazard: any ID source matches the EX slot with memread=1. Result: stall_if = stall_id = bubble_ex = 1 for exactly one cycle. The next cycle the load is in MEM and the hazard resolves via forwarding.
- Forwarding, evaluated on the EX slot's sources:
  - MEM-slot match → 1;
  - else WB-slot match → 2;
  - else 0.
  - MEM has priority over WB when both match.
  - A source with rs=0 or rs_used=0 always gets 0.
- Redirect handling:
  - `redirect` in cycle t asserts `flush_id` in cycles t .. t+FLUSH_DEPTH-1, using an internal down-counter.
  - `redirect` during an active flush reloads the counter.
  - `redirect` overrides any stall: in cycle t, stall_if = stall_id = 0 and bubble_ex = 1.
- Counters:
  - `stall_cnt` increments on each cycle stall_id=1.
  - `flush_cnt` increments on each cycle flush_id=1.
  - Both saturate at all-ones.
- Simultaneous events:
  - Load-use together with redirect: the redirect wins, and the stall is not counted.
  - `id_valid`=0: no hazard is raised and no tag is issued.

## Timing
- stall_if, stall_id, bubble_ex and flush_id are combinational from the ID inputs, `redirect` and registered state, in the same cycle.
- fwd_sel is combinational from registered state only.
- Tags take effect one cycle after `issue`.
- Load-use costs 1 bubble cycle. A redirect costs FLUSH_DEPTH flushed cycles.
- Reset (reset_n=0 at a rising edge):
  - all slots invalid;
  - flush counter = 0;
  - stall_cnt = flush_cnt = 0;
  - all outputs are 0 in the following cycle.
- Reset asserted mid-stall or mid-flush aborts it immediately.

## Configuration
- `PIPE_HAZARD_FWD_EN` defined: forwarding compiled in as described above.
- Not defined:
  - fwd_sel is tied to 0;
  - any ID source matching the EX, MEM or WB slot stalls, with stall_if = stall_id = bubble_ex = 1;
  - the stall lasts until the producer leaves WB, because the register file does not bypass.
  - The load-use special case is subsumed by this general rule.

## Test plan
- Load-use: `lw x5` issued, then ID `add x6,x5,x7`. Required: stall/bubble high for 1 cycle, stall_cnt=1; the next cycle has the add in EX with fwd_sel src0=2.
- Back-to-back ALU: `add x3,..` then `sub x4,x3,x3`. Required: no stall; fwd_sel = {1,1} while the sub is in EX.
- Priority: `addi x8` and `addi x8`, then `or x9,x8,x0`. Required: src0=1 (MEM wins), src1=0.
- x0 write: `addi x0,x0,1` then `add x1,x0,x0`. Required: no stall, fwd_sel=0.
- Redirect with FLUSH_DEPTH=2:
  - redirect pulse at t → flush_id high at t and t+1, flush_cnt=2;
  - a second redirect at t+1 extends flush through t+2.
- Without `PIPE_HAZARD_FWD_EN`: `add x3` then `sub x4,x3,x1`. Required: 3 stall cycles, stall_cnt=3, then issue.
